// File: rtl/cam_i2c_sequencer_if.sv
// Wishbone master port toward the i2c_master_wb_top register file.
interface cam_i2c_sequencer_if;
  logic [2:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_we_o;
  logic       m_cyc_o;
  logic       m_stb_o;
  logic       m_ack_i;

  modport master (output m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o,
                  input  m_dat_i, m_ack_i);
  modport slave  (input  m_adr_o, m_dat_o, m_we_o, m_cyc_o, m_stb_o,
                  output m_dat_i, m_ack_i);
endinterface

// File: rtl/cam_i2c_sequencer.sv
// Camera configuration sequencer: walks a {reg,val} table and writes each
// entry to the sensor through the I2C core's Wishbone register file.
module cam_i2c_sequencer #(
  parameter int         clk_freq = 100000000,
  parameter int         i2c_freq = 100000,
  parameter logic [6:0] dev_addr = 7'h21,
  parameter int         retries  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_idx,
  output logic [7:0]  tbl_adr,
  input  logic [15:0] tbl_dat,
  cam_i2c_sequencer_if.master m
);
  localparam int         PRESCALE  = clk_freq / (5 * i2c_freq) - 1;
  localparam logic [15:0] PRE      = PRESCALE[15:0];
  localparam logic [2:0]  RETRY_MAX = retries[2:0];

  localparam logic [2:0] A_PRERLO = 3'd0, A_PRERHI = 3'd1, A_CTR = 3'd2,
                         A_TXR    = 3'd3, A_CR     = 3'd4;

  typedef enum logic [3:0] {
    IDLE, INIT, FETCH, LOAD_TXR, WRITE_CR, POLL_SR, NEXT, NACK_STOP, NACK_POLL, FIN
  } state_t;

  state_t      state;
  logic [1:0]  step;       // INIT register counter
  logic [1:0]  byte_cnt;   // 0 addr, 1 reg, 2 val
  logic [2:0]  retry_cnt;
  logic        fetch_wait;
  logic [15:0] entry;

  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [7:0]  wdat;

  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat;
  logic        acc_we;

  assign m.m_cyc_o = cyc;
  assign m.m_stb_o = stb;
  assign m.m_we_o  = we;
  assign m.m_adr_o = adr;
  assign m.m_dat_o = wdat;

  // Access each bus state wants to issue; latched when the access launches
  always_comb begin
    acc_adr = A_PRERLO;
    acc_dat = 8'h00;
    acc_we  = 1'b1;
    case (state)
      INIT: begin
        case (step)
          2'd0:    begin acc_adr = A_PRERLO; acc_dat = PRE[7:0];  end
          2'd1:    begin acc_adr = A_PRERHI; acc_dat = PRE[15:8]; end
          default: begin acc_adr = A_CTR;    acc_dat = 8'h80;     end
        endcase
      end
      LOAD_TXR: begin
        acc_adr = A_TXR;
        case (byte_cnt)
          2'd0:    acc_dat = {dev_addr, 1'b0};
          2'd1:    acc_dat = entry[15:8];
          default: acc_dat = entry[7:0];
        endcase
      end
      WRITE_CR: begin
        acc_adr = A_CR;
        case (byte_cnt)
          2'd0:    acc_dat = 8'h90;
          2'd1:    acc_dat = 8'h10;
          default: acc_dat = 8'h50;
        endcase
      end
      POLL_SR, NACK_POLL: begin acc_adr = A_CR; acc_we = 1'b0; end
      NACK_STOP:          begin acc_adr = A_CR; acc_dat = 8'h40; end
      default: ;
    endcase
  end

  // Sequencer FSM; a held access completes on ack, and since the next
  // access only launches from cyc=0 there is always one idle cycle between
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; step <= '0; byte_cnt <= '0; retry_cnt <= '0;
      fetch_wait <= 1'b0; entry <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; err_idx <= '0; tbl_adr <= '0;
      cyc <= 1'b0; stb <= 1'b0; we <= 1'b0; adr <= '0; wdat <= '0;
    end else if (cyc) begin
      if (m.m_ack_i) begin
        cyc <= 1'b0; stb <= 1'b0; we <= 1'b0;
        case (state)
          INIT: begin
            if (step == 2'd2) begin state <= FETCH; fetch_wait <= 1'b0; end
            else step <= step + 2'd1;
          end
          LOAD_TXR: state <= WRITE_CR;
          WRITE_CR: state <= POLL_SR;
          POLL_SR: begin
            if (m.m_dat_i[1])      state <= POLL_SR;
            else if (m.m_dat_i[7]) state <= NACK_STOP;
            else if (byte_cnt == 2'd2) state <= NEXT;
            else begin byte_cnt <= byte_cnt + 2'd1; state <= LOAD_TXR; end
          end
          NACK_STOP: state <= NACK_POLL;
          NACK_POLL: begin
            if (m.m_dat_i[1]) state <= NACK_POLL;
            else if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 3'd1;
              byte_cnt  <= 2'd0;
              state     <= LOAD_TXR;
            end else begin
              err <= 1'b1; err_idx <= tbl_adr; state <= FIN;
            end
          end
          default: ;
        endcase
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done <= 1'b0; err <= 1'b0; err_idx <= '0;
            busy <= 1'b1; tbl_adr <= '0; step <= '0; retry_cnt <= '0;
            state <= INIT;
          end
        end
        FETCH: begin
          // tbl_dat trails tbl_adr by a cycle, so sample on the second cycle
          if (!fetch_wait) fetch_wait <= 1'b1;
          else begin
            fetch_wait <= 1'b0;
            entry      <= tbl_dat;
            byte_cnt   <= 2'd0;
            state      <= (tbl_dat == 16'hFFFF) ? FIN : LOAD_TXR;
          end
        end
        NEXT: begin
          retry_cnt <= '0;
          if (tbl_adr == 8'hFF) state <= FIN;
          else begin tbl_adr <= tbl_adr + 8'd1; state <= FETCH; end
        end
        FIN: begin
          busy <= 1'b0; done <= 1'b1; state <= IDLE;
        end
        default: begin
          cyc <= 1'b1; stb <= 1'b1; adr <= acc_adr; wdat <= acc_dat; we <= acc_we;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cam_i2c_sequencer.sv
// Bench: I2C core + sensor model at the Wishbone level, table-driven runs,
// transaction scoreboard, and hand-written reset/full-table sequences.
module tb_cam_i2c_sequencer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic        busy, done, err;
  logic [7:0]  err_idx, tbl_adr;
  logic [15:0] tbl_dat;

  cam_i2c_sequencer_if wb();

  cam_i2c_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .err_idx(err_idx), .tbl_adr(tbl_adr), .tbl_dat(tbl_dat), .m(wb)
  );

  always #5 clk = ~clk;

  // synchronous table ROM
  logic [15:0] rom [256];
  always @(posedge clk) tbl_dat <= rom[tbl_adr];

  // ---------------- I2C core / sensor model ----------------
  logic        ack = 1'b0, pend = 1'b0, rxack = 1'b0;
  int          tip_cnt = 0;
  logic [7:0]  txr = 8'h00, prer_lo = 8'h00, prer_hi = 8'h00, ctr = 8'h00;
  logic [23:0] cur = '0;
  int          ncur = 0, ent_ok = 0;
  bit          nacked = 1'b0, prev_busy = 1'b0, prev_cyc = 1'b0;
  logic [11:0] prev_bus = '0;
  logic [31:0] obs_log [4096];
  int          obs_n = 0, proto_err = 0;
  int          nack_ent = 0, nack_byte = 0, nack_mode = 0;

  assign wb.m_ack_i = ack;
  assign wb.m_dat_i = {rxack, 5'b0, (tip_cnt != 0), 1'b0};

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    logic nk;
    nk = 1'b0;
    case (a)
      3'd0: prer_lo = d;
      3'd1: prer_hi = d;
      3'd2: ctr     = d;
      3'd3: txr     = d;
      3'd4: begin
        if (d[7]) begin ncur = 0; cur = '0; end
        if (d[4]) begin
          nk = (nack_mode != 0) && (ent_ok == nack_ent) && (ncur == nack_byte) &&
               !(nack_mode == 1 && nacked);
          cur = {cur[15:0], txr}; ncur++;
          if (nk) nacked = 1'b1;
          rxack = nk; tip_cnt = 5;
        end else tip_cnt = 2;
        if (d[6]) begin
          if (ncur > 0 && obs_n < 4096) begin obs_log[obs_n] = {8'(ncur), cur}; obs_n++; end
          if (ncur == 3 && !nk) ent_ok++;
          ncur = 0; cur = '0;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        ack = 1'b0; pend = 1'b0; tip_cnt = 0; ncur = 0; cur = '0;
        prev_cyc = 1'b0; prev_busy = 1'b0;
      end else begin
        // bus protocol: drop after ack, hold stable until ack
        if (ack && wb.m_cyc_o) proto_err++;
        if (prev_cyc && !ack && !wb.m_cyc_o) proto_err++;
        if (prev_cyc && !ack && wb.m_cyc_o &&
            {wb.m_adr_o, wb.m_dat_o, wb.m_we_o} != prev_bus) proto_err++;
        prev_cyc = wb.m_cyc_o;
        prev_bus = {wb.m_adr_o, wb.m_dat_o, wb.m_we_o};
        if (busy && !prev_busy) begin
          ent_ok = 0; nacked = 1'b0; ncur = 0; cur = '0;
          prer_lo = 8'h00; prer_hi = 8'h00; ctr = 8'h00;
        end
        prev_busy = busy;
        if (tip_cnt > 0) tip_cnt--;
        if (wb.m_cyc_o && wb.m_stb_o && !ack) begin
          if (pend) begin
            ack = 1'b1; pend = 1'b0;
            if (wb.m_we_o) do_write(wb.m_adr_o, wb.m_dat_o);
          end else pend = 1'b1;
        end else begin
          ack = 1'b0; pend = 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int errors = 0, checks = 0, rd = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    int n; int nent; int nbyte; int mode;
    logic e; logic [7:0] eidx; logic [7:0] eadr;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int cnt, input logic [15:0] ent);
    logic [7:0]  b [3];
    logic [23:0] t;
    t = '0;
    b[0] = 8'h42; b[1] = ent[15:8]; b[2] = ent[7:0];
    for (int k = 0; k < cnt; k++) t = {t[15:0], b[k]};
    return {8'(cnt), t};
  endfunction

  task automatic build_expect(input vec_t v);
    for (int e = 0; e < v.n; e++) begin
      if (v.mode == 2 && e == v.nent) begin
        repeat (4) exp_q.push_back(pack(v.nbyte + 1, rom[e]));
        break;
      end
      if (v.mode == 1 && e == v.nent) exp_q.push_back(pack(v.nbyte + 1, rom[e]));
      exp_q.push_back(pack(3, rom[e]));
    end
  endtask

  task automatic drain(input string nm);
    chk({nm, " txn count"}, obs_n - rd, exp_q.size());
    while (rd < obs_n && exp_q.size() > 0) begin
      chk($sformatf("%s txn%0d", nm, rd), obs_log[rd], exp_q.pop_front());
      rd++;
    end
    rd = obs_n;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit mid);
    logic [7:0] a;
    for (int k = 0; k < 256; k++) rom[k] = {8'($urandom_range(0, 254)), 8'($urandom)};
    rom[0] = 16'h1280;
    if (v.n < 256) rom[v.n] = 16'hFFFF;
    nack_ent = v.nent; nack_byte = v.nbyte; nack_mode = v.mode;
    exp_q.delete();
    build_expect(v);
    pulse_start();
    chk({nm, " busy"}, busy, 1);
    chk({nm, " done clr"}, done, 0);
    if (mid) begin
      repeat (600) @(negedge clk);
      a = tbl_adr;
      pulse_start();
      chk({nm, " start ignored busy"}, busy, 1);
      chk({nm, " start ignored idx"}, 32'(tbl_adr >= a && tbl_adr != 0), 1);
    end
    for (int c = 0; c < 40000; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({nm, " finished"}, busy, 0);
    chk({nm, " done"}, done, 1);
    chk({nm, " err"}, err, v.e);
    chk({nm, " err_idx"}, err_idx, v.eidx);
    chk({nm, " tbl_adr"}, tbl_adr, v.eadr);
    chk({nm, " prer"}, {prer_hi, prer_lo}, 16'h00C7);
    chk({nm, " ctr"}, ctr, 8'h80);
    drain(nm);
    repeat (3) @(negedge clk);
    chk({nm, " done held"}, done, 1);
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 0, 1'b0, 8'd0, 8'd1};  // single entry 0x1280
    vecs[1] = '{4, 0, 0, 0, 1'b0, 8'd0, 8'd4};  // ordering
    vecs[2] = '{4, 2, 1, 1, 1'b0, 8'd0, 8'd4};  // reg byte NACK once
    vecs[3] = '{3, 1, 0, 2, 1'b1, 8'd1, 8'd1};  // addr NACK forever
    vecs[4] = '{3, 0, 2, 1, 1'b0, 8'd0, 8'd3};  // value byte NACK once
    vecs[5] = '{5, 3, 2, 2, 1'b1, 8'd3, 8'd3};  // value byte NACK forever

    for (int k = 0; k < 256; k++) rom[k] = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst err_idx", err_idx, 0);
    chk("rst tbl_adr", tbl_adr, 0);
    chk("rst cyc", wb.m_cyc_o, 0);
    chk("rst stb", wb.m_stb_o, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    // full table without terminator, plus a start pulse mid-run
    run_vec("full", '{256, 0, 0, 0, 1'b0, 8'd0, 8'd255}, 1'b1);

    // asynchronous reset in the middle of entry 1
    for (int k = 0; k < 4; k++) rom[k] = {8'($urandom_range(0, 254)), 8'($urandom)};
    rom[4] = 16'hFFFF;
    nack_mode = 0;
    exp_q.push_back(pack(3, rom[0]));
    pulse_start();
    begin
      int c;
      for (c = 0; c < 4000; c++) begin
        if (tbl_adr == 8'd1 && wb.m_cyc_o && wb.m_adr_o == 3'd3) break;
        @(negedge clk);
      end
      chk("mid reset reached entry1", 32'(c < 4000), 1);
    end
    #2 rst = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    chk("mid reset err", err, 0);
    chk("mid reset cyc", wb.m_cyc_o, 0);
    chk("mid reset stb", wb.m_stb_o, 0);
    chk("mid reset tbl_adr", tbl_adr, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("after reset idle", busy, 0);
    drain("mid reset");

    chk("bus protocol errors", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
